nes_joypad_port: RTL and testbench
==================================

# nes_joypad_port

Responder side of the NES controller-port protocol at CPU addresses $4016/$4017. It converts USB HID keycodes from the SoC into NES standard-controller button state. It latches that state on CPU strobe writes and serially returns one button per CPU read, exactly as a 4021 shift register would. The block sits inside the NES architecture between the SoC keycode export and the CPU bus decode.

## Interface
Parameters:
- P2_PRESENT, 0, when 1 port 2 mirrors port-1 buttons; when 0 port 2 reads return data bit 0 = 0.
- OPEN_BUS, 3'b010, value driven on cpu_data_out[7:5] for port reads.

Ports:
- Clk  in  1  system clock; all state updates on its rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- keycodes  in  32  four HID usage slots [7:0],[15:8],[23:16],[31:24]; 8'h00 = empty slot.
- cpu_ce  in  1  one-Clk-wide pulse marking the active phase of a CPU bus cycle.
- cpu_addr  in  16  CPU address.
- cpu_rw_n  in  1  1 = read, 0 = write.
- cpu_data_in  in  8  CPU write data.
- cpu_data_out  out  8  read data; meaningful when port_sel = 1.
- port_sel  out  1  combinational; 1 when cpu_addr is $4016 or $4017 and cpu_rw_n = 1.
- buttons  out  8  registered button state for debug LEDs.
- read_count  out  4  reads of $4016 since the last strobe fall, saturating at 15.

## Operation
- Button order is NES-standard, bit0..7: A, B, Select, Start, Up, Down, Left, Right.
- Key map (HID usage -> button):
  - 8'h0D (J) -> A
  - 8'h0E (K) -> B
  - 8'h2C (Space) -> Select
  - 8'h28 (Enter) -> Start
  - 8'h1A (W) -> Up
  - 8'h16 (S) -> Down
  - 8'h04 (A) -> Left
  - 8'h07 (D) -> Right
- A button is set if any slot matches its code. Unknown codes are ignored. Duplicate slots are harmless.
- Opposing directions: if Up and Down are both set, both are forced to 0. Left and Right follow the same rule.
- buttons is registered every Clk from the mapped, filtered result.
- Strobe register: on cpu_ce with a write to $4016, strobe <= cpu_data_in[0]. A write to $4017 does not affect this block.
- Shift registers sh1 and sh2, 8 bits each:
  - While strobe = 1, both reload from buttons every Clk. sh2 reloads 8'h00 when P2_PRESENT = 0.
  - While strobe = 0, on cpu_ce with a read of $4016: sh1 <= {1'b1, sh1[7:1]}. $4017 shifts sh2 the same way.
- cpu_data_out = {OPEN_BUS, 4'b0000, sh[0]} for the selected port. It is combinational from the current register state, so it is valid in the same cycle as cpu_ce.
- read_count:
  - Cleared on the Clk where strobe transitions 1 -> 0.
  - Increments on each $4016 read while strobe = 0, saturating at 15.
  - Held at 0 while strobe = 1.
- Reads with strobe = 1 always return the live A bit (or 0 for port 2) and do not shift.

## Timing
- Reset values (async on Reset_n low): strobe = 0, sh1 = sh2 = 8'hFF, buttons = 8'h00, read_count = 0.
  - Consequence: cpu_data_out[0] = 1 for a read issued during reset.
- keycodes -> buttons: 1 Clk latency. buttons -> shift register (strobe high): 1 further Clk. Total key-to-serial latency is 2 Clk.
- Strobe write takes effect at the Clk edge of the cpu_ce cycle. The read in the following CPU cycle sees the reloaded value.
- Shift happens at the Clk edge ending the cpu_ce read cycle. The data returned in that cycle is the pre-shift bit 0.
- Boundary cases:
  - After 8 reads, every further read returns 1 (fill bits).
  - A strobe write 1 and a read cannot coincide: one bus access per cpu_ce.
  - Reset asserted mid-sequence restores the reset values immediately. The next sequence starts fresh.
  - keycodes changing while strobe = 0 does not disturb an in-progress shift sequence.

## Test plan
- Reset with no keys. Write $4016 = 1, then 0; 8 reads -> all bit0 = 0; reads 9-10 -> 1; cpu_data_out = 8'h40 / 8'h41.
- keycodes = 32'h0000_0D28 (A + Start). Strobe 1/0, 8 reads -> bit sequence 1,0,0,1,0,0,0,0; read_count = 8.
- keycodes = {8'h1A, 8'h16, 8'h04, 8'h00} (Up + Down + Left) -> buttons = 8'h40; serial read 5 = 0, read 7 = 1.
- Strobe held at 1, keycodes toggled 8'h0D <-> 8'h00. Each $4016 read returns the live A bit with 2-Clk lag; read_count stays 0.
- Mid-sequence (after 3 reads), pulse Reset_n low. Read returns 1 and sh1 = 8'hFF. Then strobe 1/0 gives a correct fresh sequence.
- P2_PRESENT = 0: $4017 reads return bit0 = 0 ×8, then 1. P2_PRESENT = 1: $4017 sequence matches $4016.

Source files
------------

// File: rtl/nes_joypad_port.sv
// NES controller-port responder: maps USB HID keycodes to NES buttons and
// serialises them through 4021-style shift registers at $4016/$4017.
module nes_joypad_port #(
    parameter bit         P2_PRESENT = 1'b0,
    parameter logic [2:0] OPEN_BUS   = 3'b010
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [31:0] keycodes,
    input  logic        cpu_ce,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rw_n,
    input  logic [7:0]  cpu_data_in,
    output logic [7:0]  cpu_data_out,
    output logic        port_sel,
    output logic [7:0]  buttons,
    output logic [3:0]  read_count
);

    logic       strobe_q, strobe_d;
    logic [7:0] sh1_q, sh1_d;
    logic [7:0] sh2_q, sh2_d;
    logic [7:0] buttons_q, buttons_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] hit;
    logic       is_4016, is_4017;
    logic       wr16, rd16, rd17;
    logic       reload;
    logic       ser_bit;
    logic       unused_data;

    assign unused_data = ^cpu_data_in[7:1];

    assign is_4016 = (cpu_addr == 16'h4016);
    assign is_4017 = (cpu_addr == 16'h4017);
    assign wr16    = cpu_ce & ~cpu_rw_n & is_4016;
    assign rd16    = cpu_ce & cpu_rw_n & is_4016;
    assign rd17    = cpu_ce & cpu_rw_n & is_4017;

    always_comb begin
        hit = 8'h00;
        for (int s = 0; s < 4; s++) begin
            case (keycodes[s*8 +: 8])
                8'h0D:   hit[0] = 1'b1;
                8'h0E:   hit[1] = 1'b1;
                8'h2C:   hit[2] = 1'b1;
                8'h28:   hit[3] = 1'b1;
                8'h1A:   hit[4] = 1'b1;
                8'h16:   hit[5] = 1'b1;
                8'h04:   hit[6] = 1'b1;
                8'h07:   hit[7] = 1'b1;
                default: ;
            endcase
        end
        buttons_d = hit;
        // Opposing directions cancel rather than confuse game logic
        if (hit[4] && hit[5]) buttons_d[5:4] = 2'b00;
        if (hit[6] && hit[7]) buttons_d[7:6] = 2'b00;
    end

    always_comb begin
        strobe_d = wr16 ? cpu_data_in[0] : strobe_q;
        reload   = strobe_q | strobe_d;
        sh1_d    = sh1_q;
        sh2_d    = sh2_q;
        cnt_d    = cnt_q;
        if (reload) begin
            sh1_d = buttons_q;
            sh2_d = P2_PRESENT ? buttons_q : 8'h00;
            cnt_d = 4'h0;
        end else begin
            if (rd16) sh1_d = {1'b1, sh1_q[7:1]};
            if (rd17) sh2_d = {1'b1, sh2_q[7:1]};
            if (rd16 && cnt_q != 4'hF) cnt_d = cnt_q + 4'h1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            strobe_q  <= 1'b0;
            sh1_q     <= 8'hFF;
            sh2_q     <= 8'hFF;
            buttons_q <= 8'h00;
            cnt_q     <= 4'h0;
        end else begin
            strobe_q  <= strobe_d;
            sh1_q     <= sh1_d;
            sh2_q     <= sh2_d;
            buttons_q <= buttons_d;
            cnt_q     <= cnt_d;
        end
    end

    assign ser_bit      = cpu_addr[0] ? sh2_q[0] : sh1_q[0];
    assign cpu_data_out = {OPEN_BUS, 4'b0000, ser_bit};
    assign port_sel     = (is_4016 | is_4017) & cpu_rw_n;
    assign buttons      = buttons_q;
    assign read_count   = cnt_q;

endmodule

// File: tb/tb_nes_joypad_port.sv
// Bench for nes_joypad_port: two instances (port 2 absent / present)
// driven in parallel and compared against a queue-based reference model.
module tb_nes_joypad_port;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic [31:0] keycodes = 32'h0;
    logic        cpu_ce = 1'b0;
    logic [15:0] cpu_addr = 16'h0;
    logic        cpu_rw_n = 1'b1;
    logic [7:0]  cpu_data_in = 8'h0;
    logic [7:0]  dout0, dout1, btn0, btn1;
    logic        sel0, sel1;
    logic [3:0]  rc0, rc1;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [7:0] KEYMAP [8] = '{8'h0D, 8'h0E, 8'h2C, 8'h28,
                                          8'h1A, 8'h16, 8'h04, 8'h07};
    localparam logic [7:0] POOL [12] = '{8'h0D, 8'h0E, 8'h2C, 8'h28,
                                         8'h1A, 8'h16, 8'h04, 8'h07,
                                         8'h00, 8'h05, 8'hFF, 8'h2D};

    nes_joypad_port #(.P2_PRESENT(1'b0), .OPEN_BUS(3'b010)) u0 (
        .Clk(Clk), .Reset_n(Reset_n), .keycodes(keycodes),
        .cpu_ce(cpu_ce), .cpu_addr(cpu_addr), .cpu_rw_n(cpu_rw_n),
        .cpu_data_in(cpu_data_in), .cpu_data_out(dout0),
        .port_sel(sel0), .buttons(btn0), .read_count(rc0)
    );

    nes_joypad_port #(.P2_PRESENT(1'b1), .OPEN_BUS(3'b010)) u1 (
        .Clk(Clk), .Reset_n(Reset_n), .keycodes(keycodes),
        .cpu_ce(cpu_ce), .cpu_addr(cpu_addr), .cpu_rw_n(cpu_rw_n),
        .cpu_data_in(cpu_data_in), .cpu_data_out(dout1),
        .port_sel(sel1), .buttons(btn1), .read_count(rc1)
    );

    always #5 Clk = ~Clk;

    // Reference model state
    bit qa[$];
    bit qb0[$];
    bit qb1[$];
    int cnt = 0;

    function automatic logic [7:0] ref_map(input logic [31:0] k);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < 8; i++)
            for (int s = 0; s < 4; s++)
                if (k[s*8 +: 8] == KEYMAP[i]) b[i] = 1'b1;
        if (b[4] && b[5]) begin b[4] = 1'b0; b[5] = 1'b0; end
        if (b[6] && b[7]) begin b[6] = 1'b0; b[7] = 1'b0; end
        return b;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge Clk);
    endtask

    task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
        @(negedge Clk);
        cpu_ce = 1'b1; cpu_addr = a; cpu_rw_n = 1'b0; cpu_data_in = d;
        #1 chk("wr_port_sel", {7'h0, sel0}, 8'h00);
        @(posedge Clk);
        #1 cpu_ce = 1'b0; cpu_rw_n = 1'b1;
    endtask

    task automatic cpu_rd(input logic [15:0] a,
                          output logic [7:0] d0, output logic [7:0] d1);
        @(negedge Clk);
        cpu_ce = 1'b1; cpu_addr = a; cpu_rw_n = 1'b1;
        #1 d0 = dout0; d1 = dout1;
        chk("rd_port_sel", {7'h0, sel0}, 8'h01);
        @(posedge Clk);
        #1 cpu_ce = 1'b0;
    endtask

    task automatic rd_chk(input bit p2);
        logic [7:0] d0, d1;
        bit e0, e1;
        if (!p2) begin
            e0 = qa.size() > 0 ? qa.pop_front() : 1'b1;
            e1 = e0;
            if (cnt < 15) cnt++;
        end else begin
            e0 = qb0.size() > 0 ? qb0.pop_front() : 1'b1;
            e1 = qb1.size() > 0 ? qb1.pop_front() : 1'b1;
        end
        cpu_rd(p2 ? 16'h4017 : 16'h4016, d0, d1);
        chk(p2 ? "rd4017_p2off" : "rd4016_p2off", d0, {7'b0100000, e0});
        chk(p2 ? "rd4017_p2on" : "rd4016_p2on", d1, {7'b0100000, e1});
    endtask

    task automatic load_model(input logic [7:0] b);
        qa.delete(); qb0.delete(); qb1.delete();
        for (int i = 0; i < 8; i++) begin
            qa.push_back(b[i]);
            qb0.push_back(1'b0);
            qb1.push_back(b[i]);
        end
        cnt = 0;
    endtask

    task automatic do_strobe();
        cpu_wr(16'h4016, 8'h01);
        idle(2);
        cpu_wr(16'h4016, 8'hFE);
        load_model(ref_map(keycodes));
    endtask

    task automatic chk_rc();
        chk("read_count_p2off", {4'h0, rc0}, cnt[7:0]);
        chk("read_count_p2on", {4'h0, rc1}, cnt[7:0]);
    endtask

    task automatic set_keys(input logic [31:0] k);
        @(negedge Clk);
        keycodes = k;
    endtask

    initial begin
        logic [7:0] d0, d1;
        logic [31:0] k;
        bit cur_a, new_a;

        // Reset state, including a read issued while in reset
        #3;
        cpu_rd(16'h4016, d0, d1);
        chk("reset_read", d0, 8'h41);
        chk("reset_buttons", btn0, 8'h00);
        chk("reset_rc", {4'h0, rc0}, 8'h00);
        @(negedge Clk);
        Reset_n = 1'b1;
        idle(2);
        rd_chk(1'b0);
        rd_chk(1'b1);

        // No keys: eight 0s, then fill 1s
        do_strobe();
        for (int i = 0; i < 10; i++) rd_chk(1'b0);
        chk_rc();

        // A + Start
        set_keys(32'h0000_0D28);
        idle(3);
        chk("btn_a_start", btn0, 8'h09);
        do_strobe();
        for (int i = 0; i < 8; i++) rd_chk(1'b0);
        chk_rc();
        for (int i = 0; i < 9; i++) rd_chk(1'b1);

        // Up + Down + Left: vertical pair cancels
        set_keys({8'h1A, 8'h16, 8'h04, 8'h00});
        idle(3);
        chk("btn_updown_left", btn0, 8'h40);
        chk("btn_updown_left_p2on", btn1, 8'h40);
        do_strobe();
        for (int i = 0; i < 8; i++) begin
            rd_chk(1'b0);
            rd_chk(1'b1);
        end

        // Strobe held high: live A bit with 2-Clk lag, no counting
        set_keys(32'h0);
        cpu_wr(16'h4016, 8'h01);
        idle(3);
        cur_a = 1'b0;
        for (int i = 0; i < 6; i++) begin
            k = (i % 2 == 0) ? 32'h0000_000D : 32'h0;
            new_a = (i % 2 == 0);
            set_keys(k);
            @(posedge Clk);
            cpu_rd(16'h4016, d0, d1);
            chk("live_a_lag1", d0, {7'b0100000, cur_a});
            cur_a = new_a;
            cpu_rd(16'h4016, d0, d1);
            chk("live_a_lag2", d0, {7'b0100000, cur_a});
            cpu_rd(16'h4017, d0, d1);
            chk("live_p2off", d0, 8'h40);
            chk("live_p2on", d1, {7'b0100000, cur_a});
            chk("live_rc", {4'h0, rc0}, 8'h00);
        end
        idle(2);
        cpu_wr(16'h4016, 8'h00);
        load_model(ref_map(keycodes));
        for (int i = 0; i < 9; i++) rd_chk(1'b0);

        // Randomised sequences with keys changing mid-sequence
        for (int it = 0; it < 20; it++) begin
            for (int s = 0; s < 4; s++)
                k[s*8 +: 8] = POOL[$urandom_range(0, 11)];
            set_keys(k);
            idle(3);
            chk("rand_buttons", btn0, ref_map(k));
            do_strobe();
            for (int r = 0; r < int'($urandom_range(1, 12)); r++) begin
                case ($urandom_range(0, 3))
                    0: rd_chk(1'b1);
                    1: begin
                        for (int s = 0; s < 4; s++)
                            k[s*8 +: 8] = POOL[$urandom_range(0, 11)];
                        set_keys(k);
                        rd_chk(1'b0);
                    end
                    2: begin
                        cpu_wr(16'h4017, 8'($urandom_range(0, 255)));
                        rd_chk(1'b0);
                    end
                    default: rd_chk(1'b0);
                endcase
            end
            chk_rc();
        end

        // Reset mid-sequence
        set_keys(32'h0000_0D28);
        idle(3);
        do_strobe();
        for (int i = 0; i < 3; i++) rd_chk(1'b0);
        #2 Reset_n = 1'b0;
        qa.delete(); qb0.delete(); qb1.delete();
        cnt = 0;
        cpu_rd(16'h4016, d0, d1);
        chk("midrst_read", d0, 8'h41);
        chk("midrst_buttons", btn0, 8'h00);
        chk("midrst_rc", {4'h0, rc0}, 8'h00);
        @(negedge Clk);
        Reset_n = 1'b1;
        rd_chk(1'b0);
        rd_chk(1'b1);
        idle(3);
        do_strobe();
        for (int i = 0; i < 8; i++) rd_chk(1'b0);
        chk_rc();

        // read_count saturation
        set_keys({8'h0E, 8'h07, 8'h1A, 8'h2C});
        idle(3);
        do_strobe();
        for (int i = 0; i < 17; i++) rd_chk(1'b0);
        chk_rc();
        chk("rc_saturate", {4'h0, rc0}, 8'h0F);

        // Non-port address and write decode
        @(negedge Clk);
        cpu_addr = 16'h4015; cpu_rw_n = 1'b1;
        #1 chk("sel_other_addr", {7'h0, sel0}, 8'h00);
        cpu_addr = 16'h4017;
        #1 chk("sel_4017_read", {7'h0, sel1}, 8'h01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
